// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed driver for a common-anode seven-segment
// display. A double-buffered image (pending/active) is swapped only at frame
// wraps so the visible picture never tears. Adds per-digit decimal point,
// blanking, blinking and leading-zero suppression on the active image.
module seg_scan_driver #(
  parameter int DIGITS     = 8,
  parameter int DIV_WIDTH  = 17,
  parameter int BLINK_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic [DIGITS-1:0]     blink,
  input  logic                  lz_en,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            seg,
  output logic                  frame,
  output logic                  pending
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] glyph(input logic [3:0] nib);
    case (nib)
      4'h0:    glyph = 7'b1000000;
      4'h1:    glyph = 7'b1111001;
      4'h2:    glyph = 7'b0100100;
      4'h3:    glyph = 7'b0110000;
      4'h4:    glyph = 7'b0011001;
      4'h5:    glyph = 7'b0010010;
      4'h6:    glyph = 7'b0000010;
      4'h7:    glyph = 7'b1111000;
      4'h8:    glyph = 7'b0000000;
      4'h9:    glyph = 7'b0010000;
      4'hA:    glyph = 7'b0001000;
      4'hB:    glyph = 7'b0000011;
      4'hC:    glyph = 7'b1000110;
      4'hD:    glyph = 7'b0100001;
      4'hE:    glyph = 7'b0000110;
      4'hF:    glyph = 7'b0001110;
      default: glyph = 7'b1111111;
    endcase
  endfunction

  // Scan timing state
  logic [DIV_WIDTH-1:0]  cnt_q;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BLINK_LOG2-1:0] fcnt_q, fcnt_d;
  logic                  phase_q, phase_d;
  logic                  tick_s, wrap_s;

  // Pending and active image buffers
  logic [4*DIGITS-1:0]   pend_data_q, act_data_q;
  logic [DIGITS-1:0]     pend_dp_q, act_dp_q;
  logic [DIGITS-1:0]     pend_blank_q, act_blank_q;
  logic [DIGITS-1:0]     pend_blink_q, act_blink_q;
  logic                  pend_lz_q, act_lz_q;
  logic                  pend_flag_q, pend_flag_d;
  logic                  apply_s;

  // Output registers and their next values
  logic [DIGITS-1:0]     an_q, an_d;
  logic [7:0]            seg_q, seg_d;
  logic                  frame_q;

  // Display-side decode helpers
  logic [DIGITS-1:0]     supp_s;
  logic                  zero_s;
  logic                  dark_s;
  logic [3:0]            nib_s;

  assign tick_s  = &cnt_q;
  assign wrap_s  = tick_s && (idx_q == IDX_LAST);
  // The swap happens on the wrap edge; a coincident load refills pending.
  assign apply_s = wrap_s && pend_flag_q;

  // Next scan index, frame counter and blink phase.
  always_comb begin
    idx_d   = idx_q;
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (tick_s) begin
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else begin
      idx_d = idx_q;
    end
    if (wrap_s) begin
      fcnt_d = fcnt_q + 1'b1;
      if (&fcnt_q) begin
        phase_d = ~phase_q;
      end else begin
        phase_d = phase_q;
      end
    end else begin
      fcnt_d  = fcnt_q;
      phase_d = phase_q;
    end
  end

  // Prescaler, scan index, frame counter and blink phase registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      fcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_q + 1'b1;
      idx_q   <= idx_d;
      fcnt_q  <= fcnt_d;
      phase_q <= phase_d;
    end
  end

  // Pending flag: a load always (re)arms it, an applied wrap clears it.
  always_comb begin
    pend_flag_d = pend_flag_q;
    if (load) begin
      pend_flag_d = 1'b1;
    end else if (apply_s) begin
      pend_flag_d = 1'b0;
    end else begin
      pend_flag_d = pend_flag_q;
    end
  end

  // Double-buffered image: capture into pending, promote at frame wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      pend_blink_q <= '0;
      pend_lz_q    <= 1'b0;
      act_data_q   <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '0;
      act_blink_q  <= '0;
      act_lz_q     <= 1'b0;
      pend_flag_q  <= 1'b0;
    end else begin
      if (load) begin
        pend_data_q  <= data;
        pend_dp_q    <= dp;
        pend_blank_q <= blank;
        pend_blink_q <= blink;
        pend_lz_q    <= lz_en;
      end
      if (apply_s) begin
        act_data_q  <= pend_data_q;
        act_dp_q    <= pend_dp_q;
        act_blank_q <= pend_blank_q;
        act_blink_q <= pend_blink_q;
        act_lz_q    <= pend_lz_q;
      end
      pend_flag_q <= pend_flag_d;
    end
  end

  // Leading-zero mask: walk from the most significant digit downwards.
  always_comb begin
    zero_s = 1'b1;
    supp_s = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_s = zero_s & (act_data_q[4*i +: 4] == 4'h0);
      if (i > 0) begin
        supp_s[i] = act_lz_q & zero_s;
      end else begin
        supp_s[i] = 1'b0;
      end
    end
  end

  // Anode and segment pattern for the digit currently being scanned.
  always_comb begin
    an_d   = '1;
    seg_d  = 8'hFF;
    nib_s  = act_data_q[4*idx_q +: 4];
    dark_s = act_blank_q[idx_q] | supp_s[idx_q] | (act_blink_q[idx_q] & phase_q);
    if (dark_s) begin
      an_d  = '1;
      seg_d = 8'hFF;
    end else begin
      an_d  = ~(DIGITS'(1) << idx_q);
      seg_d = {~act_dp_q[idx_q], glyph(nib_s)};
    end
  end

  // Registered outputs; frame marks the cycle after each wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q    <= '1;
      seg_q   <= 8'hFF;
      frame_q <= 1'b0;
    end else begin
      an_q    <= an_d;
      seg_q   <= seg_d;
      frame_q <= wrap_s;
    end
  end

  assign an      = an_q;
  assign seg     = seg_q;
  assign frame   = frame_q;
  assign pending = pend_flag_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver with DIGITS=4, DIV_WIDTH=2, BLINK_LOG2=1:
// four cycles per digit, sixteen cycles per frame, blink phase every 2 frames.
module tb_seg_scan_driver;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] data;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic [3:0]  blink;
  logic        lz_en;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        frame;
  logic        pending;

  seg_scan_driver #(.DIGITS(4), .DIV_WIDTH(2), .BLINK_LOG2(1)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .data(data), .dp(dp),
    .blank(blank), .blink(blink), .lz_en(lz_en), .an(an), .seg(seg),
    .frame(frame), .pending(pending)
  );

  typedef struct {
    logic [15:0]     data;
    logic [3:0]      dp;
    logic [3:0]      blank;
    logic [3:0]      blink;
    logic            lz;
    logic [3:0][7:0] segs;
    logic [3:0]      dark;
  } vec_t;

  // kind: 0 = {an,seg}, 1 = frame, 2 = pending
  typedef struct {
    int          cyc;
    int          kind;
    logic [11:0] val;
    string       nm;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[8];
  int   k;
  int   n_pass;
  int   n_total;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp_v);
    n_total++;
    if (act !== exp_v) begin
      $display("FAIL %s: got %h required %h", nm, act, exp_v);
    end else begin
      n_pass++;
    end
  endtask

  task automatic push(input int cyc, input int kind, input logic [11:0] val, input string nm);
    exp_t e;
    if (cyc > k) begin
      e.cyc = cyc; e.kind = kind; e.val = val; e.nm = nm;
      sbq.push_back(e);
    end
  endtask

  // One clock: sample 1 time unit after the edge, retire matching expectations.
  task automatic step();
    @(posedge clk);
    #1;
    k++;
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].cyc == k) begin
        case (sbq[i].kind)
          0:       chk(sbq[i].nm, {an, seg}, sbq[i].val);
          1:       chk(sbq[i].nm, {11'b0, frame}, sbq[i].val);
          default: chk(sbq[i].nm, {11'b0, pending}, sbq[i].val);
        endcase
        sbq.delete(i);
      end
    end
  endtask

  task automatic run_until(input int target);
    while (k < target) step();
  endtask

  task automatic align();
    while ((k % 16) != 2) step();
  endtask

  // Expected picture for frame fn: digit d is shown at cycles 16fn+4d+1..+4.
  task automatic expect_frame(input int fn, input vec_t v, input string tag);
    logic [3:0] an_e;
    for (int d = 0; d < 4; d++) begin
      an_e = ~(4'b0001 << d);
      for (int c = 0; c < 4; c++) begin
        if (v.dark[d]) begin
          push(16*fn + 4*d + c + 1, 0, 12'hFFF, $sformatf("%s_f%0d_d%0d", tag, fn, d));
        end else begin
          push(16*fn + 4*d + c + 1, 0, {an_e, v.segs[d]}, $sformatf("%s_f%0d_d%0d", tag, fn, d));
        end
      end
    end
  endtask

  task automatic do_load(input vec_t v);
    data  = v.data;
    dp    = v.dp;
    blank = v.blank;
    blink = v.blink;
    lz_en = v.lz;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  initial begin
    vec_t zv, prev, va, vb, bv, tmp;
    int   n;
    n_pass = 0; n_total = 0; k = 0;
    rst_n = 1'b0; load = 1'b0; data = '0; dp = '0; blank = '0; blink = '0; lz_en = 1'b0;

    zv = '{16'h0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, {8'hC0, 8'hC0, 8'hC0, 8'hC0}, 4'b0000};
    vecs[0] = '{16'h12AF, 4'b0100, 4'b0000, 4'b0000, 1'b0, {8'hF9, 8'h24, 8'h88, 8'h8E}, 4'b0000};
    vecs[1] = '{16'h0030, 4'b0000, 4'b0000, 4'b0000, 1'b1, {8'hC0, 8'hC0, 8'hB0, 8'hC0}, 4'b1100};
    vecs[2] = '{16'h0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, {8'hC0, 8'hC0, 8'hC0, 8'hC0}, 4'b1110};
    vecs[3] = '{16'h1000, 4'b0000, 4'b0000, 4'b0000, 1'b1, {8'hF9, 8'hC0, 8'hC0, 8'hC0}, 4'b0000};
    vecs[4] = '{16'hCB98, 4'b0000, 4'b0000, 4'b0000, 1'b0, {8'hC6, 8'h83, 8'h90, 8'h80}, 4'b0000};
    vecs[5] = '{16'h0EDF, 4'b0000, 4'b0000, 4'b0000, 1'b0, {8'hC0, 8'h86, 8'hA1, 8'h8E}, 4'b0000};
    vecs[6] = '{16'h3210, 4'b1010, 4'b0101, 4'b0000, 1'b0, {8'h30, 8'hC0, 8'h79, 8'hC0}, 4'b0101};
    vecs[7] = '{16'h0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, {8'hC0, 8'hC0, 8'hC0, 8'hC0}, 4'b0000};
    va = '{16'hCB98, 4'b0000, 4'b0000, 4'b0000, 1'b0, {8'hC6, 8'h83, 8'h90, 8'h80}, 4'b0000};
    vb = '{16'h4567, 4'b0000, 4'b0000, 4'b0000, 1'b0, {8'h99, 8'h92, 8'h82, 8'hF8}, 4'b0000};
    bv = '{16'h0000, 4'b0000, 4'b1000, 4'b0001, 1'b0, {8'hC0, 8'hC0, 8'hC0, 8'hC0}, 4'b1000};

    // Reset state while clocks run
    repeat (3) @(posedge clk);
    #1;
    chk("rst_anseg", {an, seg}, 12'hFFF);
    chk("rst_frame", {11'b0, frame}, 12'h000);
    chk("rst_pend", {11'b0, pending}, 12'h000);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;

    // Scan from reset with a zero image; frame pulse on every 16th cycle
    expect_frame(0, zv, "boot");
    push(1, 2, 12'h000, "boot_pend");
    push(15, 1, 12'h000, "boot_frm15");
    push(16, 1, 12'h001, "boot_frm16");
    push(17, 1, 12'h000, "boot_frm17");
    prev = zv;
    align();

    // Table: load mid-frame, old picture holds, new picture next frame
    for (int i = 0; i < 8; i++) begin
      n = k / 16;
      expect_frame(n, prev, $sformatf("hold%0d", i));
      push(16*n + 3,  2, 12'h001, $sformatf("v%0d_pend_set", i));
      push(16*n + 15, 2, 12'h001, $sformatf("v%0d_pend_hold", i));
      push(16*n + 16, 2, 12'h000, $sformatf("v%0d_pend_clr", i));
      push(16*n + 15, 1, 12'h000, $sformatf("v%0d_frm_lo", i));
      push(16*n + 16, 1, 12'h001, $sformatf("v%0d_frm_hi", i));
      push(16*n + 17, 1, 12'h000, $sformatf("v%0d_frm_end", i));
      do_load(vecs[i]);
      expect_frame(n + 1, vecs[i], $sformatf("v%0d", i));
      prev = vecs[i];
      run_until(16*n + 32);
    end

    // Load A on the wrap cycle while B is pending: B next frame, A after
    align();
    n = k / 16;
    expect_frame(n, prev, "dl_hold");
    expect_frame(n + 1, vb, "dl_B");
    expect_frame(n + 2, va, "dl_A");
    push(16*n + 3,  2, 12'h001, "dl_pend_B");
    push(16*n + 16, 2, 12'h001, "dl_pend_wrap");
    push(16*n + 24, 2, 12'h001, "dl_pend_mid");
    push(16*n + 31, 2, 12'h001, "dl_pend_late");
    push(16*n + 32, 2, 12'h000, "dl_pend_clr");
    do_load(vb);
    run_until(16*n + 15);
    do_load(va);
    run_until(16*n + 48);
    prev = va;

    // Blink on digit 0 (phase = frame/2 mod 2), digit 3 blanked
    align();
    n = k / 16;
    expect_frame(n, prev, "bk_hold");
    do_load(bv);
    for (int f = n + 1; f <= n + 4; f++) begin
      tmp = bv;
      if (((f / 2) % 2) == 1) tmp.dark = 4'b1001;
      else tmp.dark = 4'b1000;
      expect_frame(f, tmp, "bk");
    end
    run_until(16*(n + 4) + 16);

    // Asynchronous reset mid-digit discards the pending image
    align();
    do_load(vecs[0]);
    chk("prerst_pend", {11'b0, pending}, 12'h001);
    run_until(k + 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_anseg", {an, seg}, 12'hFFF);
    chk("arst_frame", {11'b0, frame}, 12'h000);
    chk("arst_pend", {11'b0, pending}, 12'h000);
    @(posedge clk);
    #1;
    chk("arst_hold_anseg", {an, seg}, 12'hFFF);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    expect_frame(0, zv, "rr");
    expect_frame(1, zv, "rr");
    push(1,  2, 12'h000, "rr_pend1");
    push(16, 2, 12'h000, "rr_pend16");
    push(17, 2, 12'h000, "rr_pend17");
    push(16, 1, 12'h001, "rr_frm16");
    run_until(32);

    foreach (sbq[i]) begin
      n_total++;
      $display("FAIL %s: got no sample, required check at cycle %0d", sbq[i].nm, sbq[i].cyc);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed driver for a common-anode seven-segment display with DIGITS digits. It replaces per-digit combinational hex decoding with a single scanned segment bus. It holds a double-buffered display image and adds per-digit decimal point, blanking, blinking and leading-zero suppression. Image updates are applied only at frame boundaries, so the display never tears. It sits between the board's display pins and any logic that presents hex values to the user.

## Interface
- DIGITS, 8: number of digits scanned, 2..16.
- DIV_WIDTH, 17: prescaler width; one scan step every 2^DIV_WIDTH clocks.
- BLINK_LOG2, 6: blink phase toggles every 2^BLINK_LOG2 frames.
- clk  in  1: sole clock, rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- load  in  1: single-cycle strobe; captures data, dp, blank, blink and lz_en into the pending buffer.
- data  in  4*DIGITS: hex nibbles; digit i is data[4i+3:4i]; digit 0 is rightmost.
- dp  in  DIGITS: decimal point on, per digit.
- blank  in  DIGITS: digit forced dark, per digit.
- blink  in  DIGITS: digit dark during blink phase 1, per digit.
- lz_en  in  1: leading-zero suppression enable.
- an  out  DIGITS: anode selects, active-low, one-hot-low or all 1.
- seg  out  8: {dp,g,f,e,d,c,b,a}, active-low.
- frame  out  1: one-cycle pulse when the active image is (re)loaded or a frame wraps.
- pending  out  1: pending buffer holds data not yet applied.

## Operation
- Prescaler cnt (DIV_WIDTH bits) increments every clock and wraps. tick = (cnt == all ones).
- Scan index idx, 0..DIGITS-1: on tick, idx <= (idx==DIGITS-1) ? 0 : idx+1. A wrap happens on a tick with idx==DIGITS-1.
- load: pending buffer <= inputs and pending_flag <= 1.
- On wrap with pending_flag=1: active image <= pending buffer and pending_flag <= 0.
  - If load is asserted in the same cycle, the old pending contents move to active. The new inputs go to pending, and pending_flag stays 1.
- Frame counter fcnt (BLINK_LOG2 bits) increments on every wrap. phase toggles on each wrap where fcnt is all ones.
- Glyphs, active-low {g..a}: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Leading-zero suppression, active image only: digit i is suppressed if lz_en=1, i>0, and nibbles i..DIGITS-1 are all zero. Digit 0 is never suppressed.
- Digit i is dark if blank[i], or suppressed, or (blink[i] and phase=1).
- For the digit at idx:
  - Dark: an = all 1 and seg = 8'hFF.
  - Otherwise: an = ~(1<<idx) and seg = {~dp[idx], glyph}.
- frame pulses for one cycle, registered, on the cycle after every wrap.

## Timing
- an, seg and frame are registered. They reflect idx and the active image as of the previous clock edge, i.e. 1-cycle latency.
- Each digit is driven for exactly 2^DIV_WIDTH cycles. One frame is DIGITS*2^DIV_WIDTH cycles.
- Reset values:
  - cnt=0, idx=0, fcnt=0, phase=0, pending_flag=0.
  - Active and pending images all zero: data=0, dp=0, blank=0, blink=0, lz_en=0.
  - Outputs: an=all 1, seg=8'hFF, frame=0, pending=0.
- First clock after reset release: an=~1 and seg=8'hC0 (digit 0 shows "0").
- Load-to-display latency: at most one frame plus 1 cycle. pending falls on the wrap edge.
- Reset asserted mid-frame: all state returns to reset values immediately, asynchronously, and the pending image is discarded.
- Consecutive loads before a wrap: only the last load is applied.

## Test plan
- Reset then release, DIGITS=4, DIV_WIDTH=2. Expect:
  - an cycles 1110→1101→1011→0111, each for 4 cycles.
  - seg=8'hC0 on every digit.
  - frame pulses every 16 cycles.
- load data=16'h12AF, dp=4'b0100. Expect:
  - Nothing changes until the wrap.
  - Next frame shows digit0 seg=8'h8E (F), digit1 8'h88 (A), digit2 8'h24 (2 with dp), digit3 8'hF9 (1).
  - pending is 1 until the wrap.
- lz_en=1, data=16'h0030. Expect digits 3 and 2 dark (an all 1, seg FF), digit1=8'hB0, digit0=8'hC0. With data=0, only digit0 is lit.
- blink=4'b0001, BLINK_LOG2=1, blank=4'b1000. Expect:
  - Digit 0 dark in alternate 2-frame windows.
  - Digit 3 always dark.
- Load A asserted on the wrap cycle with load B already pending. Expect:
  - B is displayed next frame, A the frame after.
  - pending is 1 throughout, then 0 after A is applied.
- Assert rst_n low mid-digit. Expect an=all 1 and seg=FF with no clock. After release, scanning restarts at digit 0 with a zero image.
